lag_measure_multi: RTL and testbench

//  Parametrised N-channel lag measurement engine; successor to the single-sensor sensor/measure pair.

---
 rtl/lag_pkg.sv | 14 +
 rtl/lag_channel.sv | 160 ++++++++++++++++
 rtl/lag_measure_multi.sv | 63 ++++++
 tb/tb_lag_measure_multi.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lag_pkg.sv
// Shared types and constants for the multi-channel lag measurement engine.
package lag_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } lag_state_t;

  localparam int SYNC_STAGES = 2;

  // Wide all-ones pattern; channels slice it down to the lag width for min reset
  localparam logic [63:0] MIN_RESET = '1;

endpackage

// File: rtl/lag_channel.sv
// One lag channel: sensor synchroniser, debounce, timing FSM and min/max/block-average statistics.
module lag_channel
  import lag_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int AVG_LOG2      = 4,
  parameter int DEBOUNCE      = 16,
  parameter int TIMEOUT_TICKS = 20000
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             start,
  input  logic             tick,
  input  logic             clear_stats,
  input  logic             sensor,
  output logic             busy,
  output logic             meas_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] lag_cur,
  output logic [CNT_W-1:0] lag_min,
  output logic [CNT_W-1:0] lag_max,
  output logic [CNT_W-1:0] lag_avg
);

  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'((2 ** AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_INIT = MIN_RESET[CNT_W-1:0];

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [DB_W-1:0]        db_cnt;
  logic                   deb_level;
  logic                   level_flip;
  logic                   hit;

  lag_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] sum_q;
  logic [N_W-1:0]   n_q;
  logic             take_sample;

  logic [CNT_W-1:0] base_min, base_max, base_avg;
  logic [SUM_W-1:0] base_sum, sum_plus;
  logic [N_W-1:0]   base_n;
  logic [CNT_W-1:0] min_next, max_next, avg_next;
  logic [SUM_W-1:0] sum_next;
  logic [N_W-1:0]   n_next;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], sensor};
  end

  // The debounced level only moves after DEBOUNCE consecutive disagreeing samples
  assign level_flip = (synced != deb_level) && (db_cnt == DB_LAST);
  assign hit        = level_flip && synced;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      db_cnt    <= '0;
      deb_level <= 1'b0;
    end else if (synced == deb_level) begin
      db_cnt <= '0;
    end else if (level_flip) begin
      deb_level <= synced;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // A restart on the same edge discards the hit, so only accepted hits feed statistics
  assign take_sample = (state == COUNT) && hit && !start;

  always_comb begin
    base_min = clear_stats ? MIN_INIT : lag_min;
    base_max = clear_stats ? '0 : lag_max;
    base_avg = clear_stats ? '0 : lag_avg;
    base_sum = clear_stats ? '0 : sum_q;
    base_n   = clear_stats ? '0 : n_q;
    sum_plus = base_sum + SUM_W'(cnt);
    min_next = (cnt < base_min) ? cnt : base_min;
    max_next = (cnt > base_max) ? cnt : base_max;
    avg_next = base_avg;
    sum_next = sum_plus;
    n_next   = base_n + N_W'(1);
    if (base_n == N_LAST) begin
      avg_next = CNT_W'(sum_plus >> AVG_LOG2);
      sum_next = '0;
      n_next   = '0;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      lag_min <= MIN_INIT;
      lag_max <= '0;
      lag_avg <= '0;
      sum_q   <= '0;
      n_q     <= '0;
    end else begin
      lag_min <= take_sample ? min_next : base_min;
      lag_max <= take_sample ? max_next : base_max;
      lag_avg <= take_sample ? avg_next : base_avg;
      sum_q   <= take_sample ? sum_next : base_sum;
      n_q     <= take_sample ? n_next   : base_n;
    end
  end

  // Priority inside COUNT: restart, then hit, then timeout on the wrapping tick
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      lag_cur    <= '0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= COUNT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (start) begin
            cnt <= '0;
          end else if (hit) begin
            lag_cur    <= cnt;
            meas_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (tick) begin
            if (cnt == CNT_LAST) begin
              timeout <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lag_measure_multi.sv
// N-channel lag measurement top: shared tick prescaler and packing of per-channel results.
module lag_measure_multi
  import lag_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int TICK_DIV      = 2700,
  parameter int CNT_W         = 16,
  parameter int AVG_LOG2      = 4,
  parameter int DEBOUNCE      = 16,
  parameter int TIMEOUT_TICKS = 20000
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      clear_stats,
  input  logic [CHANNELS-1:0]       sensor,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       meas_valid,
  output logic [CHANNELS-1:0]       timeout,
  output logic [CHANNELS*CNT_W-1:0] lag_cur,
  output logic [CHANNELS*CNT_W-1:0] lag_min,
  output logic [CHANNELS*CNT_W-1:0] lag_max,
  output logic [CHANNELS*CNT_W-1:0] lag_avg
);

  localparam int PRE_W = $clog2(TICK_DIV + 1);

  logic [PRE_W-1:0] presc;
  logic             tick;

  assign tick = (presc == PRE_W'(TICK_DIV - 1));

  // Clearing on start aligns tick boundaries to the start edge, so lag is floor(cycles/TICK_DIV)
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn)             presc <= '0;
    else if (start || tick) presc <= '0;
    else                   presc <= presc + PRE_W'(1);
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    lag_channel #(
      .CNT_W         (CNT_W),
      .AVG_LOG2      (AVG_LOG2),
      .DEBOUNCE      (DEBOUNCE),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_ch (
      .clock       (clock),
      .rstn        (rstn),
      .start       (start),
      .tick        (tick),
      .clear_stats (clear_stats),
      .sensor      (sensor[k]),
      .busy        (busy[k]),
      .meas_valid  (meas_valid[k]),
      .timeout     (timeout[k]),
      .lag_cur     (lag_cur[k*CNT_W +: CNT_W]),
      .lag_min     (lag_min[k*CNT_W +: CNT_W]),
      .lag_max     (lag_max[k*CNT_W +: CNT_W]),
      .lag_avg     (lag_avg[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_lag_measure_multi.sv
// Scoreboard bench for lag_measure_multi: directed runs push expected events, a negedge monitor pops them.
module tb_lag_measure_multi;

  localparam int CHANNELS      = 2;
  localparam int TICK_DIV      = 10;
  localparam int CNT_W         = 16;
  localparam int AVG_LOG2      = 2;
  localparam int DEBOUNCE      = 4;
  localparam int TIMEOUT_TICKS = 500;
  localparam int TO_CYCLES     = TIMEOUT_TICKS * TICK_DIV;
  localparam int HIT_EDGE      = 1 + DEBOUNCE;
  localparam int RUN_LIMIT     = 12000;

  typedef struct packed {
    logic        is_timeout;
    logic [15:0] cur;
    logic [15:0] mn;
    logic [15:0] mx;
    logic [15:0] avg;
    logic [63:0] due;
  } exp_t;

  logic                      clock = 1'b0;
  logic                      rstn;
  logic                      start;
  logic                      clear_stats;
  logic [CHANNELS-1:0]       sensor;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS-1:0]       meas_valid;
  logic [CHANNELS-1:0]       timeout;
  logic [CHANNELS*CNT_W-1:0] lag_cur;
  logic [CHANNELS*CNT_W-1:0] lag_min;
  logic [CHANNELS*CNT_W-1:0] lag_max;
  logic [CHANNELS*CNT_W-1:0] lag_avg;

  int     vectors     = 0;
  int     miscompares = 0;
  longint cyc         = 0;
  exp_t   q0[$];
  exp_t   q1[$];

  lag_measure_multi #(
    .CHANNELS      (CHANNELS),
    .TICK_DIV      (TICK_DIV),
    .CNT_W         (CNT_W),
    .AVG_LOG2      (AVG_LOG2),
    .DEBOUNCE      (DEBOUNCE),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clock       (clock),
    .rstn        (rstn),
    .start       (start),
    .clear_stats (clear_stats),
    .sensor      (sensor),
    .busy        (busy),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .lag_cur     (lag_cur),
    .lag_min     (lag_min),
    .lag_max     (lag_max),
    .lag_avg     (lag_avg)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t mk(input logic to, input int c, input int mn, input int mx, input int a);
    exp_t e;
    e.is_timeout = to;
    e.cur        = 16'(c);
    e.mn         = 16'(mn);
    e.mx         = 16'(mx);
    e.avg        = 16'(a);
    e.due        = '0;
    return e;
  endfunction

  task automatic cmp(input string name, input int ch, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s ch%0d: got %0d, expected %0d (t=%0t)", name, ch, act, req, $time);
    end
  endtask

  task automatic check_output(input int ch);
    exp_t e;
    int   pending;
    pending = (ch == 0) ? q0.size() : q1.size();
    if (pending == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected_event ch%0d: got meas_valid=%0b timeout=%0b, expected no event (t=%0t)",
               ch, meas_valid[ch], timeout[ch], $time);
      return;
    end
    if (ch == 0) e = q0.pop_front();
    else         e = q1.pop_front();
    cmp("event_kind", ch, 64'(timeout[ch]), 64'(e.is_timeout));
    cmp("lag_cur", ch, 64'(lag_cur[ch*CNT_W +: CNT_W]), 64'(e.cur));
    cmp("lag_min", ch, 64'(lag_min[ch*CNT_W +: CNT_W]), 64'(e.mn));
    cmp("lag_max", ch, 64'(lag_max[ch*CNT_W +: CNT_W]), 64'(e.mx));
    cmp("lag_avg", ch, 64'(lag_avg[ch*CNT_W +: CNT_W]), 64'(e.avg));
    cmp("busy_at_event", ch, 64'(busy[ch]), 64'd0);
    if (e.is_timeout) cmp("timeout_cycle", ch, 64'(cyc), e.due);
  endtask

  always @(negedge clock) begin
    for (int ch = 0; ch < CHANNELS; ch++)
      if (meas_valid[ch] || timeout[ch]) check_output(ch);
  end

  task automatic check_reset_values();
    for (int ch = 0; ch < CHANNELS; ch++) begin
      cmp("rst_busy", ch, 64'(busy[ch]), 64'd0);
      cmp("rst_meas_valid", ch, 64'(meas_valid[ch]), 64'd0);
      cmp("rst_timeout", ch, 64'(timeout[ch]), 64'd0);
      cmp("rst_lag_cur", ch, 64'(lag_cur[ch*CNT_W +: CNT_W]), 64'd0);
      cmp("rst_lag_min", ch, 64'(lag_min[ch*CNT_W +: CNT_W]), 64'hFFFF);
      cmp("rst_lag_max", ch, 64'(lag_max[ch*CNT_W +: CNT_W]), 64'd0);
      cmp("rst_lag_avg", ch, 64'(lag_avg[ch*CNT_W +: CNT_W]), 64'd0);
    end
  endtask

  // Offsets count negedges after the start edge; 0 means "never rises"
  task automatic apply_stimulus(input int off0, input int off1, input int glitch0,
                                input int restart_at, input int clear_at,
                                input exp_t e0, input exp_t e1);
    longint base;
    int     t;
    bit     done;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    base  = cyc;
    e0.due = 64'(base + ((restart_at > 0) ? restart_at : 0) + TO_CYCLES);
    e1.due = e0.due;
    q0.push_back(e0);
    q1.push_back(e1);
    t    = 1;
    done = 1'b0;
    while (!done && t <= RUN_LIMIT) begin
      if (t == 2) cmp("busy_after_start", 0, 64'(busy), 64'(2'b11));
      sensor[0]   = ((off0 > 0) && (t >= off0)) ||
                    ((glitch0 > 0) && (t >= glitch0) && (t < glitch0 + 3));
      sensor[1]   = (off1 > 0) && (t >= off1);
      start       = (t == restart_at);
      clear_stats = (t == clear_at);
      @(negedge clock);
      if (q0.size() == 0 && q1.size() == 0) done = 1'b1;
      t++;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL run_completion: got %0d/%0d events pending, expected 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    sensor      = '0;
    start       = 1'b0;
    clear_stats = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic apply_reset_mid_run();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int t = 1; t <= 1200; t++) begin
      sensor[0] = (t >= 800);
      if (t == 500) rstn = 1'b0;
      if (t == 503) begin
        cmp("busy_in_reset", 0, 64'(busy), 64'd0);
        cmp("lag_cur_in_reset", 0, 64'(lag_cur[0 +: CNT_W]), 64'd0);
        cmp("lag_min_in_reset", 0, 64'(lag_min[0 +: CNT_W]), 64'hFFFF);
      end
      if (t == 504) rstn = 1'b1;
      @(negedge clock);
    end
    check_reset_values();
    sensor = '0;
    repeat (12) @(negedge clock);
  endtask

  initial begin
    rstn        = 1'b0;
    start       = 1'b0;
    clear_stats = 1'b0;
    sensor      = '0;
    repeat (3) @(negedge clock);
    check_reset_values();
    rstn = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values();

    // lag = floor((offset + 2 + DEBOUNCE) / TICK_DIV); block of 4 samples per average
    apply_stimulus(1000, 300, 0, 0, 0, mk(0, 100, 100, 100, 0),   mk(0, 30, 30, 30, 0));
    apply_stimulus(2000, 500, 0, 0, 0, mk(0, 200, 100, 200, 0),   mk(0, 50, 30, 50, 0));
    apply_stimulus(3000, 400, 0, 0, 0, mk(0, 300, 100, 300, 0),   mk(0, 40, 30, 50, 0));
    apply_stimulus(4000, 200, 0, 0, 0, mk(0, 400, 100, 400, 250), mk(0, 20, 20, 50, 35));
    // No sensor: both channels time out, stats untouched
    apply_stimulus(0, 0, 0, 0, 0, mk(1, 400, 100, 400, 250), mk(1, 20, 20, 50, 35));
    // Glitch ignored; restart lands on the hit edge, sensor already high -> timeout
    apply_stimulus(600, 0, 200, 600 + HIT_EDGE, 0,
                   mk(1, 400, 100, 400, 250), mk(1, 20, 20, 50, 35));
    // clear_stats on ch0's hit edge; ch1 already sampled 30 earlier in the run
    apply_stimulus(700, 300, 0, 0, 700 + HIT_EDGE,
                   mk(0, 70, 70, 70, 0), mk(0, 30, 20, 50, 35));
    apply_stimulus(900, 500, 0, 0, 0,  mk(0, 90, 70, 90, 0),    mk(0, 50, 50, 50, 0));
    apply_stimulus(1100, 100, 0, 0, 0, mk(0, 110, 70, 110, 0),  mk(0, 10, 10, 50, 0));
    apply_stimulus(1300, 600, 0, 0, 0, mk(0, 130, 70, 130, 100), mk(0, 60, 10, 60, 0));
    apply_reset_mid_run();
    apply_stimulus(250, 150, 0, 0, 0, mk(0, 25, 25, 25, 0), mk(0, 15, 15, 15, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 200000 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
